// File: rtl/i2c_reg_write_master.sv
//==============================================================================
// Module      : i2c_reg_write_master
// Description : Single-master I2C write sequencer: START, {addr,W}, register
//               pointer, data byte, STOP, with ACK checking on every byte.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_reg_write_master #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int          CLK_DIV    = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] reg_addr,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int                 CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t           state_q,   state_d;
    logic [1:0]       qtr_q,     qtr_d;
    logic [2:0]       bit_q,     bit_d;
    logic [1:0]       byte_q,    byte_d;
    logic [23:0]      shift_q,   shift_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             ack_err_q, ack_err_d;
    logic             scl_q,     scl_d;
    logic             sda_oe_q,  sda_oe_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic             accept;
    logic             tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            shift_q   <= 24'd0;
            cnt_q     <= '0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The DONE cycle reports busy=0, so a new request is accepted there too.
    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign tick   = busy_q && (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        ack_err_d = ack_err_q;
        cnt_d     = (busy_q && !tick) ? (cnt_q + 1'b1) : '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d   = ST_START;
                    qtr_d     = 2'd0;
                    bit_d     = 3'd0;
                    byte_d    = 2'd0;
                    shift_d   = {SLAVE_ADDR, 1'b0, 6'b0, reg_addr, wr_data};
                    ack_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (qtr_q == 2'd0) begin
                        qtr_d = 2'd1;
                    end else begin
                        state_d = ST_BIT;
                        qtr_d   = 2'd0;
                        bit_d   = 3'd0;
                        byte_d  = 2'd0;
                    end
                end
            end
            ST_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if (qtr_q == 2'd3) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            state_d = ST_ACK;
                            bit_d   = 3'd0;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    if ((qtr_q == 2'd2) && sda_in) begin
                        ack_err_d = 1'b1;
                    end
                    // ack_err_q already reflects this byte's ACK by the last quarter.
                    if (qtr_q == 2'd3) begin
                        if (ack_err_q || (byte_q == 2'd2)) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_BIT;
                            byte_d  = byte_q + 1'b1;
                            bit_d   = 3'd0;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        state_d = ST_DONE;
                        qtr_d   = 2'd0;
                    end else begin
                        qtr_d   = qtr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                qtr_d   = 2'd0;
            end
        endcase
    end

    // Pin levels are decoded from the next state so they register cleanly.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_START: begin
                scl_d    = (qtr_d == 2'd0);
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_BIT: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~shift_d[23];
                busy_d   = 1'b1;
            end
            ST_ACK: begin
                scl_d    = qtr_d[1];
                sda_oe_d = 1'b0;
                busy_d   = 1'b1;
            end
            ST_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = (qtr_d != 2'd2);
                busy_d   = 1'b1;
            end
            ST_DONE: begin
                done_d   = 1'b1;
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    assign scl     = scl_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

`default_nettype wire
